// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: FSM states, ALU class
// codes, opcode/func constants, and the Moore control-word table.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_MEMADDR, ST_MEM_RD,
        ST_MEM_WR, ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP, ST_TRAP
    } state_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_SLTIU = 3'b011;
    localparam logic [2:0] ALU_SLTI  = 3'b100;
    localparam logic [2:0] ALU_LUI   = 3'b101;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // One-hot instruction class; rtype excludes JR, bad covers everything unsupported.
    typedef struct packed {
        logic rtype;
        logic jr;
        logic addiu;
        logic slti;
        logic sltiu;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic jal;
        logic bad;
    } iclass_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
    } ctrl_t;

    // State-only control word; the FETCH ack and BRANCH zero terms are added by the FSM.
    function automatic ctrl_t moore_ctrl(input state_t st, input iclass_t c);
        ctrl_t o;
        o = '0;
        case (st)
            ST_FETCH: begin
                o.mem_req   = 1'b1;
                o.alu_src_b = 2'b01;
            end
            ST_DECODE: o.alu_src_b = 2'b11;
            ST_EXEC_R: begin
                o.alu_op    = ALU_RTYPE;
                o.alu_src_a = 1'b1;
                if (c.jr) begin
                    o.pc_write  = 1'b1;
                    o.pc_source = 2'b11;
                end
            end
            ST_EXEC_I: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = 2'b10;
                o.alu_op    = c.sltiu ? ALU_SLTIU :
                              c.slti  ? ALU_SLTI  :
                              c.lui   ? ALU_LUI   : ALU_ADD;
            end
            ST_MEMADDR: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = 2'b10;
            end
            ST_MEM_RD: o.mem_req = 1'b1;
            ST_MEM_WR: begin
                o.mem_req = 1'b1;
                o.mem_we  = 1'b1;
            end
            ST_WB_R: begin
                o.reg_write = 1'b1;
                o.reg_dst   = 2'b01;
            end
            ST_WB_I: o.reg_write = 1'b1;
            ST_WB_MEM: begin
                o.reg_write  = 1'b1;
                o.mem_to_reg = 2'b01;
            end
            ST_BRANCH: begin
                o.alu_op    = ALU_SUB;
                o.alu_src_a = 1'b1;
                o.pc_source = 2'b01;
            end
            ST_JUMP: begin
                o.pc_write  = 1'b1;
                o.pc_source = 2'b10;
                if (c.jal) begin
                    o.reg_write  = 1'b1;
                    o.reg_dst    = 2'b10;
                    o.mem_to_reg = 2'b10;
                end
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational opcode/func classifier producing a one-hot instruction class.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output iclass_t    cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    FN_ADDU, FN_SUBU, FN_OR, FN_SLT, FN_SLL: cls.rtype = 1'b1;
                    FN_JR:                                   cls.jr    = 1'b1;
                    default:                                 cls.bad   = 1'b1;
                endcase
            end
            OP_ADDIU: cls.addiu = 1'b1;
            OP_SLTI:  cls.slti  = 1'b1;
            OP_SLTIU: cls.sltiu = 1'b1;
            OP_LUI:   cls.lui   = 1'b1;
            OP_LW:    cls.lw    = 1'b1;
            OP_SW:    cls.sw    = 1'b1;
            OP_BEQ:   cls.beq   = 1'b1;
            OP_BNE:   cls.bne   = 1'b1;
            OP_J:     cls.j     = 1'b1;
            OP_JAL:   cls.jal   = 1'b1;
            default:  cls.bad   = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control FSM with retired-instruction counter.
// Optional MIPS_MC_CTRL_ILLEGAL_TRAP_EN: unsupported instructions trap and raise `illegal`.
module mips_mc_control
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    input  logic        zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  alu_op,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_source,
    output logic [31:0] instret
`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic        illegal
`endif
);

    state_t      state_q, state_d;
    iclass_t     cls_q, cls_d, cls_dec;
    ctrl_t       ctl_q;
    logic [31:0] instret_q;
    logic        retire;
    logic        in_fetch, in_branch;

    mips_ctrl_decode u_decode (
        .opcode (opcode),
        .func   (func),
        .cls    (cls_dec)
    );

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (mem_ack) state_d = ST_DECODE;
            ST_DECODE: begin
                cls_d = cls_dec;
                if (cls_dec.bad) begin
`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
                    state_d = ST_TRAP;
`else
                    state_d = ST_FETCH;
`endif
                end else if (cls_dec.rtype | cls_dec.jr) begin
                    state_d = ST_EXEC_R;
                end else if (cls_dec.addiu | cls_dec.slti | cls_dec.sltiu | cls_dec.lui) begin
                    state_d = ST_EXEC_I;
                end else if (cls_dec.lw | cls_dec.sw) begin
                    state_d = ST_MEMADDR;
                end else if (cls_dec.beq | cls_dec.bne) begin
                    state_d = ST_BRANCH;
                end else if (cls_dec.j | cls_dec.jal) begin
                    state_d = ST_JUMP;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC_R:  state_d = cls_q.jr ? ST_FETCH : ST_WB_R;
            ST_EXEC_I:  state_d = ST_WB_I;
            ST_MEMADDR: state_d = cls_q.lw ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:  if (mem_ack) state_d = ST_WB_MEM;
            ST_MEM_WR:  if (mem_ack) state_d = ST_FETCH;
            ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
            ST_TRAP:    state_d = ST_TRAP;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Staying in FETCH while waiting is not a retirement; only arrivals count.
    assign retire = (state_d == ST_FETCH) && (state_q != ST_FETCH) &&
                    (state_q != ST_IDLE) && (state_q != ST_TRAP);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cls_q     <= '0;
            ctl_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            ctl_q   <= moore_ctrl(state_d, cls_d);
            if (retire) instret_q <= instret_q + 32'd1;
        end
    end

`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            illegal_q <= 1'b0;
        end else if (state_d == ST_TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`endif

    assign in_fetch  = (state_q == ST_FETCH);
    assign in_branch = (state_q == ST_BRANCH);

    assign mem_req    = ctl_q.mem_req;
    assign mem_we     = ctl_q.mem_we;
    assign alu_op     = ctl_q.alu_op;
    assign reg_write  = ctl_q.reg_write;
    assign reg_dst    = ctl_q.reg_dst;
    assign mem_to_reg = ctl_q.mem_to_reg;
    assign alu_src_a  = ctl_q.alu_src_a;
    assign alu_src_b  = ctl_q.alu_src_b;
    assign pc_source  = ctl_q.pc_source;
    assign ir_write   = in_fetch & mem_ack;
    assign pc_write   = ctl_q.pc_write | (in_fetch & mem_ack) |
                        (in_branch & (zero ^ cls_q.bne));
    assign instret    = instret_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized and directed bench for mips_mc_control against an instruction-level model.
module tb_mips_mc_control;

    logic        clk = 1'b0;
    logic        resetn;
    logic [5:0]  opcode, func;
    logic        zero, mem_ack;
    logic        mem_req, mem_we, pc_write, ir_write, reg_write, alu_src_a;
    logic [2:0]  alu_op;
    logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic [31:0] instret;
`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_instret;

    localparam int K_R = 0, K_JR = 1, K_I = 2, K_LW = 3, K_SW = 4;
    localparam int K_BR = 5, K_J = 6, K_JAL = 7, K_BAD = 8;

    mips_mc_control dut (
        .clk        (clk),
        .resetn     (resetn),
        .opcode     (opcode),
        .func       (func),
        .zero       (zero),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .alu_op     (alu_op),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_source  (pc_source),
        .instret    (instret)
`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal    (illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                if (fn == 6'h08) return K_JR;
                if (fn == 6'h21 || fn == 6'h23 || fn == 6'h25 || fn == 6'h2A || fn == 6'h00)
                    return K_R;
                return K_BAD;
            end
            6'h02: return K_J;
            6'h03: return K_JAL;
            6'h04, 6'h05: return K_BR;
            6'h09, 6'h0A, 6'h0B, 6'h0F: return K_I;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            default: return K_BAD;
        endcase
    endfunction

    // Brings the DUT out of reset and leaves the bench at a negedge inside FETCH.
    task automatic do_reset();
        @(negedge clk);
        resetn  = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_instret", instret, 32'd0);
`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
`endif
        @(negedge clk);
        #3 resetn = 1'b1;
        @(negedge clk);
        exp_instret = 32'd0;
    endtask

    // Runs one instruction from its first FETCH cycle up to the next FETCH and
    // compares the aggregate behaviour with what the instruction class requires.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zv,
                             input int fdly, input int ddly);
        int         kind, cyc, wcnt, n_pcw, n_irw, n_regw, n_we;
        int         want_cyc, want_pcw, want_regw, want_we, code;
        logic [1:0] dst_seen, m2r_seen, pcs_seen, want_dst, want_m2r, want_pcs;
        logic [7:0] alu_seen;
        bit         left, fs, done, taken;
        string      t;
        kind = kind_of(op, fn);
        cyc = 0; wcnt = 0; n_pcw = 0; n_irw = 0; n_regw = 0; n_we = 0;
        dst_seen = 2'b00; m2r_seen = 2'b00; pcs_seen = 2'b00; alu_seen = 8'h00;
        left = 1'b0; done = 1'b0;
        opcode = op; func = fn; zero = zv;
        for (int k = 0; k < 64; k++) begin
            fs = mem_req && !mem_we && (alu_src_b == 2'b01);
            if (fs && left) begin
                done = 1'b1;
                break;
            end
            if (!fs) left = 1'b1;
            mem_ack = mem_req && (wcnt >= (fs ? fdly : ddly));
            wcnt = mem_ack ? 0 : (mem_req ? wcnt + 1 : 0);
            #1;
            cyc++;
            n_pcw += int'(pc_write);
            n_irw += int'(ir_write);
            alu_seen[alu_op] = 1'b1;
            if (reg_write) begin
                n_regw++;
                dst_seen = reg_dst;
                m2r_seen = mem_to_reg;
            end
            if (mem_we) n_we++;
            if (pc_write && !fs) pcs_seen = pc_source;
            @(negedge clk);
        end
        mem_ack = 1'b0;

        t = $sformatf("op%02h_fn%02h", op, fn);
        if (!done) begin
            chk({t, "_timeout"}, 32'd1, 32'd0);
            do_reset();
            return;
        end

        taken = (op == 6'h04) ? zv : !zv;
        case (kind)
            K_R:   want_cyc = 4;
            K_I:   want_cyc = 4;
            K_LW:  want_cyc = 5 + ddly;
            K_SW:  want_cyc = 4 + ddly;
            K_BAD: want_cyc = 2;
            default: want_cyc = 3;
        endcase
        want_cyc += fdly;
        want_pcw  = 1 + int'(kind == K_JR || kind == K_J || kind == K_JAL ||
                             (kind == K_BR && taken));
        want_regw = int'(kind == K_R || kind == K_I || kind == K_LW || kind == K_JAL);
        want_we   = (kind == K_SW) ? ddly + 1 : 0;
        want_dst  = (kind == K_R) ? 2'b01 : (kind == K_JAL) ? 2'b10 : 2'b00;
        want_m2r  = (kind == K_LW) ? 2'b01 : (kind == K_JAL) ? 2'b10 : 2'b00;
        want_pcs  = (kind == K_JR) ? 2'b11 : (kind == K_BR) ? 2'b01 : 2'b10;
        case (kind)
            K_R, K_JR: code = 2;
            K_BR:      code = 1;
            K_I:       code = (op == 6'h0B) ? 3 : (op == 6'h0A) ? 4 : (op == 6'h0F) ? 5 : 0;
            default:   code = 0;
        endcase

        exp_instret = exp_instret + 32'd1;
        $display("instr op=%02h func=%02h zero=%0d fdly=%0d ddly=%0d cycles=%0d instret=%0d",
                 op, fn, zv, fdly, ddly, cyc, instret);
        chk({t, "_cycles"},  cyc,    want_cyc);
        chk({t, "_instret"}, instret, exp_instret);
        chk({t, "_ir_write"}, n_irw, 1);
        chk({t, "_pc_write"}, n_pcw, want_pcw);
        chk({t, "_reg_write"}, n_regw, want_regw);
        chk({t, "_mem_we"},  n_we,   want_we);
        chk({t, "_alu_op"},  {31'd0, alu_seen[code]}, 32'd1);
        if (want_regw == 1) begin
            chk({t, "_reg_dst"},    {30'd0, dst_seen}, {30'd0, want_dst});
            chk({t, "_mem_to_reg"}, {30'd0, m2r_seen}, {30'd0, want_m2r});
        end
        if (want_pcw == 2) chk({t, "_pc_source"}, {30'd0, pcs_seen}, {30'd0, want_pcs});
    endtask

    logic [5:0] op_tab [16];
    logic [5:0] fn_tab [8];

    initial begin
        logic [5:0] rop, rfn;
        op_tab = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h09,
                   6'h0A, 6'h0B, 6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h01, 6'h14};
        fn_tab = '{6'h21, 6'h23, 6'h25, 6'h2A, 6'h00, 6'h08, 6'h07, 6'h20};
        resetn = 1'b0; opcode = 6'h00; func = 6'h00; zero = 1'b0; mem_ack = 1'b0;
        exp_instret = 32'd0;

        #3;
        chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset_pc_write", {31'd0, pc_write}, 32'd0);
        chk("reset_alu_src_b", {30'd0, alu_src_b}, 32'd0);
        chk("reset_instret", instret, 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        chk("first_fetch_req", {31'd0, mem_req}, 32'd1);
        chk("first_fetch_srcb", {30'd0, alu_src_b}, 32'd1);

        run_instr(6'h00, 6'h21, 1'b0, 0, 0);   // addu
        run_instr(6'h23, 6'h00, 1'b0, 2, 1);   // lw
        run_instr(6'h05, 6'h00, 1'b1, 0, 0);   // bne not taken
        run_instr(6'h05, 6'h00, 1'b0, 1, 0);   // bne taken
        run_instr(6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
        run_instr(6'h03, 6'h00, 1'b0, 0, 0);   // jal
        run_instr(6'h0B, 6'h00, 1'b0, 0, 0);   // sltiu
        run_instr(6'h00, 6'h08, 1'b0, 0, 0);   // jr
        run_instr(6'h2B, 6'h00, 1'b0, 0, 2);   // sw
`ifndef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0);   // unsupported -> NOP
`endif

        // Reset while a store is waiting for its data ack.
        opcode = 6'h2B; func = 6'h00;
        mem_ack = 1'b1;
        #1;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (mem_we) break;
            @(negedge clk);
        end
        chk("mw_reached", {31'd0, mem_we}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("mw_rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("mw_rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("mw_rst_instret", instret, 32'd0);
        mem_ack = 1'b1;
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        #1;
        chk("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
        chk("late_ack_ir_write", {31'd0, ir_write}, 32'd0);
        chk("late_ack_pc_write", {31'd0, pc_write}, 32'd0);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("post_rst_fetch", {31'd0, mem_req & ~mem_we}, 32'd1);
        chk("post_rst_srcb", {30'd0, alu_src_b}, 32'd1);
        chk("post_rst_instret", instret, 32'd0);
        exp_instret = 32'd0;

`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
        opcode = 6'h3F; func = 6'h00;
        mem_ack = 1'b1;
        #1;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (4) @(negedge clk);
        chk("trap_illegal", {31'd0, illegal}, 32'd1);
        chk("trap_mem_req", {31'd0, mem_req}, 32'd0);
        chk("trap_pc_write", {31'd0, pc_write}, 32'd0);
        chk("trap_reg_write", {31'd0, reg_write}, 32'd0);
        chk("trap_instret", instret, 32'd0);
        repeat (5) @(negedge clk);
        chk("trap_illegal_held", {31'd0, illegal}, 32'd1);
        do_reset();
`endif

        for (int n = 0; n < 40; n++) begin
            do begin
                rop = op_tab[$urandom_range(0, 15)];
                rfn = fn_tab[$urandom_range(0, 7)];
`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
            end while (kind_of(rop, rfn) == K_BAD);
`else
            end while (1'b0);
`endif
            run_instr(rop, rfn, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
